multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 116 +++++++++++
 tb/tb_multicycle_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WB/TRAP with a memory handshake,
// a latched opcode for post-decode control and a wrapping retired-instruction counter.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write_en,
    output logic        ir_write_en,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic        reg_write_en,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        mem_to_reg_en,
    output logic        instr_done,
    output logic        illegal_instr,
    output logic [2:0]  state,
    output logic [15:0] retired_count
);

    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StDecode  = 3'd1,
        StExecute = 3'd2,
        StMem     = 3'd3,
        StWb      = 3'd4,
        StTrap    = 3'd5
    } state_e;

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpI     = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    state_e      state_q;
    logic [6:0]  op_q;
    logic [15:0] cnt_q;

    logic opcode_legal;
    logic is_r, is_load, is_store;

    assign opcode_legal = (opcode == OpR) || (opcode == OpI) ||
                          (opcode == OpLoad) || (opcode == OpStore);
    assign is_r     = (op_q == OpR);
    assign is_load  = (op_q == OpLoad);
    assign is_store = (op_q == OpStore);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            op_q    <= 7'd0;
            cnt_q   <= 16'd0;
        end else begin
            // Assigned every cycle; wraps naturally at 16 bits.
            cnt_q <= cnt_q + {15'd0, instr_done};
            case (state_q)
                StFetch:   if (mem_ready) state_q <= StDecode;
                StDecode: begin
                    op_q    <= opcode;
                    state_q <= opcode_legal ? StExecute : StTrap;
                end
                StExecute: state_q <= (is_load || is_store) ? StMem : StWb;
                StMem:     if (mem_ready) state_q <= is_load ? StWb : StFetch;
                StWb:      state_q <= StFetch;
                StTrap:    state_q <= StFetch;
                default:   state_q <= StFetch;
            endcase
        end
    end

    // Outputs are decoded from state and the handshake so FETCH/MEM can respond in-cycle;
    // reset forces everything low, including the debug state and the count.
    always_comb begin
        pc_write_en   = 1'b0;
        ir_write_en   = 1'b0;
        mem_read_en   = 1'b0;
        mem_write_en  = 1'b0;
        reg_write_en  = 1'b0;
        alu_src       = 1'b0;
        alu_op        = 2'b00;
        mem_to_reg_en = 1'b0;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        if (!reset) begin
            case (state_q)
                StFetch: begin
                    mem_read_en = 1'b1;
                    pc_write_en = mem_ready;
                    ir_write_en = mem_ready;
                end
                StExecute: begin
                    alu_op  = (is_load || is_store) ? 2'b00 : 2'b10;
                    alu_src = !is_r;
                end
                StMem: begin
                    alu_src      = 1'b1;
                    mem_read_en  = is_load;
                    mem_write_en = is_store;
                    instr_done   = is_store && mem_ready;
                end
                StWb: begin
                    reg_write_en  = 1'b1;
                    mem_to_reg_en = is_load;
                    instr_done    = 1'b1;
                end
                StTrap:  illegal_instr = 1'b1;
                default: ;
            endcase
        end
    end

    assign state         = reset ? 3'd0 : state_q;
    assign retired_count = reset ? 16'd0 : cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each step applies inputs, checks every output against a
// hand-computed vector, then advances one clock.
module tb_multicycle_ctrl;

    logic        clk, reset, mem_ready;
    logic [6:0]  opcode;
    logic        pc_write_en, ir_write_en, mem_read_en, mem_write_en, reg_write_en;
    logic        alu_src, mem_to_reg_en, instr_done, illegal_instr;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic [15:0] retired_count;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write_en   (pc_write_en),
        .ir_write_en   (ir_write_en),
        .mem_read_en   (mem_read_en),
        .mem_write_en  (mem_write_en),
        .reg_write_en  (reg_write_en),
        .alu_src       (alu_src),
        .alu_op        (alu_op),
        .mem_to_reg_en (mem_to_reg_en),
        .instr_done    (instr_done),
        .illegal_instr (illegal_instr),
        .state         (state),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] OpR = 7'b0110011, OpI = 7'b0010011, OpLd = 7'b0000011;
    localparam logic [6:0] OpSt = 7'b0100011, OpBad = 7'b1111111;

    // {state, pc, ir, mrd, mwr, rwr, alu_src, alu_op, m2r, done, illegal}
    localparam logic [13:0] VZero      = 14'd0;
    localparam logic [13:0] VFetchWait = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00,
                                          1'b0, 1'b0, 1'b0};
    localparam logic [13:0] VFetchGo   = {3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00,
                                          1'b0, 1'b0, 1'b0};
    localparam logic [13:0] VDecode    = {3'd1, 11'd0};
    localparam logic [13:0] VExecR     = {3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10,
                                          1'b0, 1'b0, 1'b0};
    localparam logic [13:0] VExecI     = {3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10,
                                          1'b0, 1'b0, 1'b0};
    localparam logic [13:0] VExecLs    = {3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00,
                                          1'b0, 1'b0, 1'b0};
    localparam logic [13:0] VMemLoad   = {3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00,
                                          1'b0, 1'b0, 1'b0};
    localparam logic [13:0] VMemStWait = {3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00,
                                          1'b0, 1'b0, 1'b0};
    localparam logic [13:0] VMemStDone = {3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00,
                                          1'b0, 1'b1, 1'b0};
    localparam logic [13:0] VWbRi      = {3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,
                                          1'b0, 1'b1, 1'b0};
    localparam logic [13:0] VWbLoad    = {3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,
                                          1'b1, 1'b1, 1'b0};
    localparam logic [13:0] VTrap      = {3'd5, 10'd0, 1'b1};

    // Entered just after a rising edge; applies inputs, checks, then advances one cycle.
    task automatic cyc(input string tag, input logic rdy, input logic [6:0] op,
                       input logic [13:0] exp);
        logic [13:0] obs;
        mem_ready = rdy;
        opcode    = op;
        #1;
        obs = {state, pc_write_en, ir_write_en, mem_read_en, mem_write_en, reg_write_en,
               alu_src, alu_op, mem_to_reg_en, instr_done, illegal_instr};
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] exp);
        #1;
        n_tests++;
        assert (retired_count === exp) else begin
            n_fail++;
            $error("FAIL %s: retired_count observed %h expected %h", tag, retired_count, exp);
        end
    endtask

    task automatic run_r(input string tag);
        cyc({tag, " fetch"}, 1'b1, 7'd0, VFetchGo);
        cyc({tag, " decode"}, 1'b1, OpR, VDecode);
        cyc({tag, " execute"}, 1'b1, OpR, VExecR);
        cyc({tag, " wb"}, 1'b1, OpR, VWbRi);
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; opcode = 7'd0;
        @(posedge clk);
        #1;
        cyc("reset outputs", 1'b1, 7'd0, VZero);
        chk_cnt("reset count", 16'd0);
        reset = 1'b0;

        // R-type, no stalls: 0,1,2,4
        cyc("r fetch", 1'b1, 7'd0, VFetchGo);
        cyc("r decode", 1'b1, OpR, VDecode);
        cyc("r execute", 1'b1, OpR, VExecR);
        chk_cnt("r count before wb", 16'd0);
        cyc("r wb", 1'b1, OpR, VWbRi);
        chk_cnt("r count", 16'd1);

        // I-type
        cyc("i fetch", 1'b1, 7'd0, VFetchGo);
        cyc("i decode", 1'b1, OpI, VDecode);
        cyc("i execute", 1'b1, OpI, VExecI);
        cyc("i wb", 1'b1, OpI, VWbRi);
        chk_cnt("i count", 16'd2);

        // LOAD: 2 stalls in FETCH, 3 in MEM, 10 cycles total
        cyc("ld fetch wait1", 1'b0, 7'd0, VFetchWait);
        cyc("ld fetch wait2", 1'b0, 7'd0, VFetchWait);
        cyc("ld fetch", 1'b1, 7'd0, VFetchGo);
        cyc("ld decode", 1'b1, OpLd, VDecode);
        cyc("ld execute", 1'b1, OpLd, VExecLs);
        cyc("ld mem wait1", 1'b0, OpLd, VMemLoad);
        cyc("ld mem wait2", 1'b0, OpLd, VMemLoad);
        cyc("ld mem wait3", 1'b0, OpLd, VMemLoad);
        cyc("ld mem", 1'b1, OpLd, VMemLoad);
        cyc("ld wb", 1'b1, OpLd, VWbLoad);
        chk_cnt("ld count", 16'd3);

        // STORE with one MEM stall; done only on the ready cycle
        cyc("st fetch", 1'b1, 7'd0, VFetchGo);
        cyc("st decode", 1'b1, OpSt, VDecode);
        cyc("st execute", 1'b1, OpSt, VExecLs);
        cyc("st mem wait", 1'b0, OpSt, VMemStWait);
        cyc("st mem", 1'b1, OpSt, VMemStDone);
        chk_cnt("st count", 16'd4);

        // Illegal opcode traps and retires nothing
        cyc("bad fetch", 1'b1, 7'd0, VFetchGo);
        cyc("bad decode", 1'b1, OpBad, VDecode);
        cyc("bad trap", 1'b1, OpBad, VTrap);
        chk_cnt("bad count", 16'd4);
        cyc("bad next fetch", 1'b0, 7'd0, VFetchWait);

        // Opcode flips to LOAD after decode; R behaviour must persist
        cyc("flip fetch", 1'b1, 7'd0, VFetchGo);
        cyc("flip decode", 1'b1, OpR, VDecode);
        cyc("flip execute", 1'b1, OpLd, VExecR);
        cyc("flip wb", 1'b1, OpLd, VWbRi);
        chk_cnt("flip count", 16'd5);

        // Preload the counter near the top, then retire three instructions across the wrap
        force dut.cnt_q = 16'hFFFD;
        cyc("wrap fetch wait", 1'b0, 7'd0, VFetchWait);
        release dut.cnt_q;
        chk_cnt("wrap preload", 16'hFFFD);
        run_r("wrap1");
        chk_cnt("wrap count1", 16'hFFFE);
        run_r("wrap2");
        chk_cnt("wrap count2", 16'hFFFF);
        run_r("wrap3");
        chk_cnt("wrap count3", 16'h0000);
        run_r("post wrap");
        chk_cnt("post wrap count", 16'h0001);

        // Reset clears the count; then abort a stalled LOAD in MEM
        reset = 1'b1;
        cyc("reset2", 1'b1, 7'd0, VZero);
        reset = 1'b0;
        chk_cnt("reset2 count", 16'd0);
        cyc("abort fetch", 1'b1, 7'd0, VFetchGo);
        cyc("abort decode", 1'b1, OpLd, VDecode);
        cyc("abort execute", 1'b1, OpLd, VExecLs);
        cyc("abort mem wait", 1'b0, OpLd, VMemLoad);
        reset = 1'b1;
        cyc("abort reset cyc1", 1'b1, OpLd, VZero);
        chk_cnt("abort count in reset", 16'd0);
        cyc("abort reset cyc2", 1'b1, OpLd, VZero);
        reset = 1'b0;
        cyc("abort first fetch", 1'b0, 7'd0, VFetchWait);
        chk_cnt("abort count", 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
